// File: rtl/anim_frame_player.sv
// Sprite-animation player: sweeps a screen rectangle one pixel per cycle, addresses the
// frame ROMs and steps the animation frame only on sweep boundaries so frames never tear.
module anim_frame_player #(
    parameter int X_START     = 30,
    parameter int X_END       = 131,
    parameter int Y_START     = 0,
    parameter int Y_END       = 119,
    parameter int N_FRAMES    = 7,
    parameter int FRAME_TICKS = 25_000_000,
    parameter int ROM_LATENCY = 1,
    parameter int COLOR_W     = 3
) (
    input  logic               Clock,
    input  logic               resetn,
    input  logic               enable,
    input  logic [1:0]         mode,
    output logic [3:0]         frame_idx,
    output logic [14:0]        pix_addr,
    input  logic [COLOR_W-1:0] rom_color,
    output logic [7:0]         x,
    output logic [6:0]         y,
    output logic [COLOR_W-1:0] color,
    output logic               plot,
    output logic               done
);

    typedef enum logic [1:0] {
        MODE_LOOP    = 2'd0,
        MODE_PING    = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int                TICK_W     = $clog2(FRAME_TICKS + 1);
    localparam logic [7:0]        X_FIRST    = 8'(X_START);
    localparam logic [7:0]        X_LAST     = 8'(X_END);
    localparam logic [6:0]        Y_FIRST    = 7'(Y_START);
    localparam logic [6:0]        Y_LAST     = 7'(Y_END);
    localparam logic [3:0]        LAST_FRAME = 4'(N_FRAMES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);

    logic              soft_rst;
    logic              run;
    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              pending_q, pending_d;
    logic [3:0]        frame_q, frame_d;
    dir_e              dir_q, dir_d;
    logic              done_q, done_d;
    logic              eos;
    logic              tick_tc;
    logic              advance;
    mode_e             mode_s;

    // Deasserting enable is treated exactly like reset: everything restarts from the origin.
    assign soft_rst = !resetn || !enable;
    assign run      = !soft_rst;
    assign mode_s   = mode_e'(mode);

    always_comb begin : scan_next
        x_d = x_q + 8'd1;
        y_d = y_q;
        eos = 1'b0;
        if (x_q == X_LAST) begin
            x_d = X_FIRST;
            if (y_q == Y_LAST) begin
                y_d = Y_FIRST;
                eos = 1'b1;
            end else begin
                y_d = y_q + 7'd1;
            end
        end
    end

    // A terminal count landing on the EOS cycle still advances this sweep; ticks never queue.
    assign tick_tc   = (tick_q == TICK_LAST);
    assign tick_d    = tick_tc ? '0 : tick_q + TICK_ONE;
    assign advance   = eos && (pending_q || tick_tc);
    assign pending_d = advance ? 1'b0 : (pending_q || tick_tc);

    always_comb begin : frame_next
        frame_d = frame_q;
        dir_d   = dir_q;
        done_d  = done_q;
        if (mode_s != MODE_ONESHOT) begin
            done_d = 1'b0;
        end
        if (advance) begin
            case (mode_s)
                MODE_LOOP: begin
                    frame_d = (frame_q == LAST_FRAME) ? 4'd0 : frame_q + 4'd1;
                end
                MODE_PING: begin
                    if (LAST_FRAME == 4'd0) begin
                        frame_d = 4'd0;
                    end else if (dir_q == DIR_UP) begin
                        if (frame_q == LAST_FRAME) begin
                            dir_d   = DIR_DOWN;
                            frame_d = frame_q - 4'd1;
                        end else begin
                            frame_d = frame_q + 4'd1;
                        end
                    end else begin
                        if (frame_q == 4'd0) begin
                            dir_d   = DIR_UP;
                            frame_d = 4'd1;
                        end else begin
                            frame_d = frame_q - 4'd1;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (frame_q != LAST_FRAME) begin
                        frame_d = frame_q + 4'd1;
                    end
                    if (frame_d == LAST_FRAME) begin
                        done_d = 1'b1;
                    end
                end
                default: begin
                    frame_d = frame_q;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (soft_rst) begin
            x_q       <= X_FIRST;
            y_q       <= Y_FIRST;
            tick_q    <= '0;
            pending_q <= 1'b0;
            frame_q   <= 4'd0;
            dir_q     <= DIR_UP;
            done_q    <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
            frame_q   <= frame_d;
            dir_q     <= dir_d;
            done_q    <= done_d;
        end
    end

    generate
        if (ROM_LATENCY == 0) begin : g_no_pipe
            assign x    = x_q;
            assign y    = y_q;
            assign plot = run;
        end else begin : g_pipe
            logic [7:0]             x_pipe_q [ROM_LATENCY];
            logic [6:0]             y_pipe_q [ROM_LATENCY];
            logic [ROM_LATENCY-1:0] vld_pipe_q;

            // NOTE: this pipeline is reset element by element (unlike a RAM) so in-flight pixels are dropped.
            always_ff @(posedge Clock) begin
                if (soft_rst) begin
                    for (int i = 0; i < ROM_LATENCY; i++) begin
                        x_pipe_q[i] <= X_FIRST;
                        y_pipe_q[i] <= Y_FIRST;
                    end
                    vld_pipe_q <= '0;
                end else begin
                    x_pipe_q[0]   <= x_q;
                    y_pipe_q[0]   <= y_q;
                    vld_pipe_q[0] <= 1'b1;
                    for (int i = 1; i < ROM_LATENCY; i++) begin
                        x_pipe_q[i]   <= x_pipe_q[i-1];
                        y_pipe_q[i]   <= y_pipe_q[i-1];
                        vld_pipe_q[i] <= vld_pipe_q[i-1];
                    end
                end
            end

            assign x    = x_pipe_q[ROM_LATENCY-1];
            assign y    = y_pipe_q[ROM_LATENCY-1];
            assign plot = vld_pipe_q[ROM_LATENCY-1];
        end
    endgenerate

    assign pix_addr  = {8'd0, y_q} * 15'd160 + {7'd0, x_q};
    assign color     = plot ? rom_color : '0;
    assign frame_idx = frame_q;
    assign done      = done_q;

endmodule

// File: tb/tb_anim_frame_player.sv
// Directed bench for anim_frame_player: a scan-position model plus per-sweep frame tables
// feed a pixel scoreboard that is compared whenever the DUT plots.
module tb_anim_frame_player;

    localparam int XS  = 0;
    localparam int XE  = 3;
    localparam int YS  = 0;
    localparam int YE  = 1;
    localparam int NF  = 3;
    localparam int LAT = 1;
    localparam int CW  = 3;

    logic          Clock  = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    mode   = 2'd0;
    logic [CW-1:0] rom_color   = '0;
    logic [CW-1:0] rom_color_s = '0;
    logic [3:0]    frame_idx, frame_idx_s;
    logic [14:0]   pix_addr, pix_addr_s;
    logic [7:0]    x, x_s;
    logic [6:0]    y, y_s;
    logic [CW-1:0] color, color_s;
    logic          plot, plot_s, done, done_s;

    anim_frame_player #(
        .X_START(XS), .X_END(XE), .Y_START(YS), .Y_END(YE),
        .N_FRAMES(NF), .FRAME_TICKS(5), .ROM_LATENCY(LAT), .COLOR_W(CW)
    ) dut (
        .Clock(Clock), .resetn(resetn), .enable(enable), .mode(mode),
        .frame_idx(frame_idx), .pix_addr(pix_addr), .rom_color(rom_color),
        .x(x), .y(y), .color(color), .plot(plot), .done(done)
    );

    anim_frame_player #(
        .X_START(XS), .X_END(XE), .Y_START(YS), .Y_END(YE),
        .N_FRAMES(NF), .FRAME_TICKS(20), .ROM_LATENCY(LAT), .COLOR_W(CW)
    ) dut_slow (
        .Clock(Clock), .resetn(resetn), .enable(enable), .mode(mode),
        .frame_idx(frame_idx_s), .pix_addr(pix_addr_s), .rom_color(rom_color_s),
        .x(x_s), .y(y_s), .color(color_s), .plot(plot_s), .done(done_s)
    );

    always #5 Clock = ~Clock;

    // Frame ROMs: every pixel of frame f reads back f+1, one cycle after addressing.
    always @(posedge Clock) begin
        rom_color   <= CW'(frame_idx + 4'd1);
        rom_color_s <= CW'(frame_idx_s + 4'd1);
    end

    typedef struct {
        int px;
        int py;
        int pc;
    } pix_t;

    pix_t sb[$];
    int   tab_f[$];
    int   tab_s[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   mx = XS, my = YS, sweep_n = 0, cyc = 0;
    int   done_from  = -1;
    int   done_until = 0;
    bit   prev_en  = 1'b0;
    bit   chk_slow = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs mid-cycle, queue this cycle's pixel, then step the model.
    task automatic cycle();
        bit   en;
        bit   exp_done;
        pix_t p;
        int   c;
        en = resetn && enable;
        @(negedge Clock);
        check("pix_addr", pix_addr, my * 160 + mx);
        check("plot", plot, prev_en);
        if (prev_en) begin
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                p = sb.pop_front();
                check("x", x, p.px);
                check("y", y, p.py);
                if (p.pc >= 0) check("color", color, p.pc);
            end
        end else begin
            check("x_idle", x, XS);
            check("y_idle", y, YS);
            check("color_idle", color, 0);
        end
        if (sweep_n < tab_f.size()) check("frame_idx", frame_idx, tab_f[sweep_n]);
        exp_done = (done_from >= 0) && (sweep_n >= done_from) && (cyc <= done_until);
        check("done", done, exp_done);
        if (chk_slow) begin
            check("slow_pix_addr", pix_addr_s, my * 160 + mx);
            check("slow_plot", plot_s, prev_en);
            if (sweep_n < tab_s.size()) check("slow_frame_idx", frame_idx_s, tab_s[sweep_n]);
        end
        if (en) begin
            c = (sweep_n < tab_f.size()) ? tab_f[sweep_n] + 1 : -1;
            sb.push_back('{mx, my, c});
        end
        @(posedge Clock);
        #1;
        prev_en = en;
        if (en) begin
            cyc++;
            if (mx == XE) begin
                mx = XS;
                if (my == YE) begin
                    my = YS;
                    sweep_n++;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end else begin
            mx      = XS;
            my      = YS;
            sweep_n = 0;
            cyc     = 0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        @(posedge Clock);
        #1;

        // Reset state.
        tab_f = '{0};
        run(3);
        resetn = 1'b1;

        // Loop mode: sweep order, frames 0,1,2,0,1, first plot one cycle in.
        mode   = 2'd0;
        tab_f  = '{0, 1, 2, 0, 1, 2};
        enable = 1'b1;
        run(40);

        // Ping-pong over eight sweeps.
        enable = 1'b0;
        run(1);
        mode   = 2'd1;
        tab_f  = '{0, 1, 2, 1, 0, 1, 2, 1, 0};
        enable = 1'b1;
        run(64);

        // One-shot: reaches frame 2, holds, done; leaving one-shot clears done and loops again.
        enable = 1'b0;
        run(1);
        mode       = 2'd2;
        tab_f      = '{0, 1, 2, 2, 2, 0, 1, 2};
        done_from  = 2;
        done_until = 1000;
        enable     = 1'b1;
        run(35);
        mode       = 2'd0;
        done_until = 35;
        run(21);
        done_from  = -1;

        // Slow tick: the frame only changes after the cycle-23 EOS.
        enable = 1'b0;
        run(1);
        mode     = 2'd0;
        tab_f    = '{0, 1, 2, 0, 1, 2};
        tab_s    = '{0, 0, 0, 1, 1, 2, 2};
        chk_slow = 1'b1;
        enable   = 1'b1;
        run(48);
        chk_slow = 1'b0;

        // Mid-sweep disable at cycle 13, then a clean restart.
        enable = 1'b0;
        run(1);
        tab_f  = '{0, 1, 2, 0, 1, 2};
        enable = 1'b1;
        run(13);
        enable = 1'b0;
        run(2);
        enable = 1'b1;
        run(40);

        // Hold mode, then a reset pulse while enabled.
        enable = 1'b0;
        run(1);
        mode   = 2'd3;
        tab_f  = '{0, 0, 0, 0, 0, 0, 0};
        enable = 1'b1;
        run(40);
        resetn = 1'b0;
        run(2);
        resetn = 1'b1;
        run(8);
        enable = 1'b0;
        run(2);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
